// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - valid/ready stream bundle for pipe_skid_reg
interface pipe_skid_reg_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline register stage, optionally with a skid entry
// SKID=1 breaks the ready path with a second entry; SKID=0 is a plain register.
module pipe_skid_reg #(
  parameter int                DATA_W  = 32,
  parameter int                SKID    = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  pipe_skid_reg_if.slave         in_bus,
  pipe_skid_reg_if.master        out_bus,
  output logic [1:0]             occupancy
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              skid_full;
  logic [DATA_W-1:0] skid_data;
  logic              ready;
  logic              in_xfer;
  logic              main_load;

  // Skid mode derives ready purely from state so out_ready never reaches in_ready.
  if (SKID != 0) begin : g_skid_ready
    assign ready = rst_n & ~skid_full;
  end else begin : g_reg_ready
    assign ready = rst_n & (~main_valid | out_bus.ready);
  end

  assign in_xfer   = in_bus.valid & ready;
  assign main_load = ~main_valid | out_bus.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= RST_VAL;
      skid_full  <= 1'b0;
      skid_data  <= RST_VAL;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= RST_VAL;
      skid_full  <= 1'b0;
      skid_data  <= RST_VAL;
    end else if (main_load) begin
      if (skid_full) begin
        // Older skid beat goes first; a full skid blocks input, so it empties here.
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_full  <= 1'b0;
      end else if (in_xfer) begin
        main_valid <= 1'b1;
        main_data  <= in_bus.data;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer && SKID != 0) begin
      skid_full <= 1'b1;
      skid_data <= in_bus.data;
    end
  end

  assign in_bus.ready  = ready;
  assign out_bus.valid = main_valid;
  assign out_bus.data  = main_data;
  assign occupancy     = {1'b0, main_valid} + {1'b0, skid_full};

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;
  localparam int          W       = 32;
  localparam logic [31:0] RV      = 32'h5A5A_5A5A;
  localparam int          RND_CYC = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_n_r;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  pipe_skid_reg_if #(.DATA_W(W)) s1_in (), s1_out ();
  logic       s1_flush;
  logic [1:0] s1_occ;
  pipe_skid_reg #(.DATA_W(W), .SKID(1), .RST_VAL(RV)) u_s1 (
    .clk(clk), .rst_n(rst_n), .flush(s1_flush),
    .in_bus(s1_in), .out_bus(s1_out), .occupancy(s1_occ)
  );

  pipe_skid_reg_if #(.DATA_W(W)) s0_in (), s0_out ();
  logic       s0_flush;
  logic [1:0] s0_occ;
  pipe_skid_reg #(.DATA_W(W), .SKID(0), .RST_VAL(RV)) u_s0 (
    .clk(clk), .rst_n(rst_n), .flush(s0_flush),
    .in_bus(s0_in), .out_bus(s0_out), .occupancy(s0_occ)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eo;
    logic        er;
  } vec_t;

  vec_t tbl[19];

  initial begin
    rst_n_r = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_r = 1'b1;
  end

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int RS = (g % 2 == 0) ? 1 : 0;
    localparam int RW = (g < 2) ? 1 : 64;

    pipe_skid_reg_if #(.DATA_W(RW)) ri (), ro ();
    logic        rfl;
    logic [1:0]  rocc;
    logic [63:0] q[$];
    logic        hv;
    logic [63:0] hd;
    logic [63:0] rnd;
    logic        exp_r;
    logic        ixf;
    logic        oxf;

    pipe_skid_reg #(.DATA_W(RW), .SKID(RS)) u_dut (
      .clk(clk), .rst_n(rst_n_r), .flush(rfl),
      .in_bus(ri), .out_bus(ro), .occupancy(rocc)
    );

    initial begin
      rfl = 1'b0; ri.valid = 1'b0; ri.data = '0; ro.ready = 1'b0; hv = 1'b0;
      repeat (4) @(negedge clk);
      for (int c = 0; c < RND_CYC; c++) begin
        @(negedge clk);
        if (hv) chk($sformatf("rnd%0d_stall_stable", g), 64'(ro.data), hd);
        chk($sformatf("rnd%0d_valid", g), 64'(ro.valid), 64'(q.size() != 0));
        chk($sformatf("rnd%0d_occ", g), 64'(rocc), 64'(q.size()));
        rnd      = {$urandom, $urandom};
        rfl      = ($urandom_range(15) == 0);
        ri.valid = 1'($urandom_range(1));
        ri.data  = rnd[RW-1:0];
        ro.ready = 1'($urandom_range(1));
        #1;
        exp_r = (RS != 0) ? (q.size() < 2) : (q.size() == 0 || ro.ready);
        chk($sformatf("rnd%0d_in_ready", g), 64'(ri.ready), 64'(exp_r));
        ixf = ri.valid & exp_r;
        oxf = ro.valid & ro.ready;
        if (oxf && q.size() != 0) chk($sformatf("rnd%0d_data", g), 64'(ro.data), q.pop_front());
        if (rfl) q.delete();
        else if (ixf) q.push_back(64'(ri.data));
        hv = ro.valid & ~ro.ready & ~rfl;
        hd = 64'(ro.data);
      end
      rfl = 1'b0; ri.valid = 1'b0; ro.ready = 1'b0;
    end
  end

  initial begin
    //           fl    iv    d      ordy  ev    ed     eo    er
    tbl[0]  = '{1'b0, 1'b1, 32'h1,  1'b1, 1'b1, 32'h1,  2'd1, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 32'h2,  1'b1, 1'b1, 32'h2,  2'd1, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 32'h3,  1'b1, 1'b1, 32'h3,  2'd1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h3,  2'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 32'hA,  1'b0, 1'b1, 32'hA,  2'd1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 32'hA,  2'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 32'hA,  2'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hB,  2'd1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'hB,  2'd0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 32'hA,  1'b0, 1'b1, 32'hA,  2'd1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 32'hA,  2'd2, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 32'hC,  1'b0, 1'b0, RV,     2'd0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, RV,     2'd0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 32'h22, 2'd1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h22, 2'd1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h22, 2'd1, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 32'h33, 2'd1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h33, 2'd0, 1'b1};

    rst_n = 1'b0;
    s1_flush = 1'b0; s1_in.valid = 1'b0; s1_in.data = '0; s1_out.ready = 1'b0;
    s0_flush = 1'b0; s0_in.valid = 1'b0; s0_in.data = '0; s0_out.ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_s1_valid", 64'(s1_out.valid), 64'd0);
    chk("rst_s1_in_ready", 64'(s1_in.ready), 64'd0);
    chk("rst_s1_occ", 64'(s1_occ), 64'd0);
    chk("rst_s1_data", 64'(s1_out.data), 64'(RV));
    chk("rst_s0_in_ready", 64'(s0_in.ready), 64'd0);
    chk("rst_s0_data", 64'(s0_out.data), 64'(RV));

    rst_n = 1'b1;
    #1;
    chk("rel_s1_in_ready", 64'(s1_in.ready), 64'd1);

    for (int i = 0; i < 19; i++) begin
      s1_flush     = tbl[i].fl;
      s1_in.valid  = tbl[i].iv;
      s1_in.data   = tbl[i].d;
      s1_out.ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 64'(s1_out.valid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i), 64'(s1_out.data), 64'(tbl[i].ed));
      chk($sformatf("vec%0d_occ", i), 64'(s1_occ), 64'(tbl[i].eo));
      chk($sformatf("vec%0d_in_ready", i), 64'(s1_in.ready), 64'(tbl[i].er));
    end
    s1_flush = 1'b0; s1_in.valid = 1'b0; s1_out.ready = 1'b0;

    // async reset with two beats held
    s1_in.valid = 1'b1; s1_in.data = 32'hA;
    @(negedge clk);
    s1_in.data = 32'hB;
    @(negedge clk);
    s1_in.valid = 1'b0;
    chk("arst_pre_occ", 64'(s1_occ), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(s1_out.valid), 64'd0);
    chk("arst_in_ready", 64'(s1_in.ready), 64'd0);
    chk("arst_occ", 64'(s1_occ), 64'd0);
    chk("arst_data", 64'(s1_out.data), 64'(RV));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_rel_in_ready", 64'(s1_in.ready), 64'd1);
    s1_in.valid = 1'b1; s1_in.data = 32'h77; s1_out.ready = 1'b1;
    @(negedge clk);
    s1_in.valid = 1'b0;
    chk("arst_first_valid", 64'(s1_out.valid), 64'd1);
    chk("arst_first_data", 64'(s1_out.data), 64'h77);
    @(negedge clk);
    chk("arst_drained", 64'(s1_out.valid), 64'd0);

    // single-entry: in_ready follows out_ready combinationally
    s0_in.valid = 1'b1; s0_in.data = 32'h7;
    #1;
    chk("se_empty_in_ready", 64'(s0_in.ready), 64'd1);
    @(negedge clk);
    chk("se_load_data", 64'(s0_out.data), 64'h7);
    s0_in.data = 32'h5;
    #1;
    chk("se_stall_in_ready", 64'(s0_in.ready), 64'd0);
    s0_out.ready = 1'b1;
    #1;
    chk("se_comb_in_ready", 64'(s0_in.ready), 64'd1);
    @(negedge clk);
    s0_in.valid = 1'b0;
    chk("se_next_valid", 64'(s0_out.valid), 64'd1);
    chk("se_next_data", 64'(s0_out.data), 64'h5);
    @(negedge clk);
    chk("se_drained", 64'(s0_out.valid), 64'd0);

    repeat (RND_CYC + 10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, sets the payload width in bits; legal range 1..256.
REQ-002 Parameter SKID, default 1, selects the mode: 0 gives a single-entry register, 1 gives a two-entry skid buffer.
REQ-003 Parameter RST_VAL, default all-zero DATA_W bits, is the payload value loaded on reset and on flush.
REQ-004 Port clk, input, 1 bit, is the clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1 bit, is the reset: asynchronous, active-low.
REQ-006 Port flush, input, 1 bit, discards all held entries.
REQ-007 Port in_valid, input, 1 bit, means the upstream beat is valid.
REQ-008 Port in_data, input, DATA_W bits, is the upstream payload.
REQ-009 Port in_ready, output, 1 bit, means the block accepts a beat this cycle.
REQ-010 Port out_valid, output, 1 bit, means the downstream beat is valid.
REQ-011 Port out_data, output, DATA_W bits, is the downstream payload; it is registered.
REQ-012 Port out_ready, input, 1 bit, means downstream accepts the beat.
REQ-013 Port occupancy, output, 2 bits, is the number of held entries: 0..1 when SKID=0, 0..2 when SKID=1.

Function
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both 1 at a clock edge.
REQ-015 An output transfer SHALL occur when out_valid and out_ready are both 1 at a clock edge.
REQ-016 The block SHALL deliver beats in order, with no duplication or loss except by flush.
REQ-017 Latency SHALL be 1 cycle: a beat accepted at edge N appears on out_valid/out_data after edge N when the main entry is free.
REQ-018 When SKID=0, in_ready SHALL equal (!out_valid | out_ready), a combinational path from out_ready.
REQ-019 When SKID=1, in_ready SHALL equal !skid_full, driven from a register only, with no combinational path from out_ready.
REQ-020 Main-entry load, when the main entry is empty or an output transfer occurs:
- source is the skid entry if it is full, otherwise the input beat if an input transfer occurs;
- otherwise out_valid goes to 0.
REQ-021 When SKID=1, an input transfer that is not consumed by the main entry SHALL be written to the skid entry, setting skid_full.
REQ-022 When the skid entry drains into the main entry and an input transfer occurs at the same edge, the input beat SHALL go to the skid entry if the main entry stays occupied, preserving order.
REQ-023 out_data SHALL hold its value, bit-stable, while out_valid=1 and out_ready=0.
REQ-024 out_data SHALL be don't-care while out_valid=0, but it is implemented as holding its last value.
REQ-025 Flush SHALL take priority over every transfer. At the next edge:
- out_valid=0 and skid_full=0;
- out_data=RST_VAL;
- occupancy=0.
REQ-026 An input beat offered in a flush cycle SHALL be discarded, even if in_ready=1.
REQ-027 An output transfer in a flush cycle still counts as delivered downstream.
REQ-028 in_ready SHALL be 1 in the cycle after a flush.
REQ-029 Simultaneous input and output transfers with occupancy 1 SHALL leave occupancy at 1, with the new beat in the main entry.
REQ-030 When occupancy is 2 (SKID=1), in_ready SHALL be 0; an output transfer then moves the skid entry to main, and in_ready rises in the next cycle.

Reset
REQ-031 While rst_n=0, all of the following SHALL hold:
- out_valid=0 and skid_full=0;
- out_data=RST_VAL;
- occupancy=0;
- in_ready=0, gated by rst_n.
REQ-032 Reset assertion mid-transfer SHALL abandon all held beats immediately, asynchronously.
REQ-033 Deassertion of rst_n SHALL take effect at the first rising edge of clk after release; in_ready SHALL be 1 in the first cycle after release.

Verification
REQ-034 Streaming test: SKID=1, DATA_W=32, out_ready=1, in_valid=1 with data 0x1,0x2,0x3 on consecutive edges -> out_data 0x1,0x2,0x3 on the three following cycles, occupancy=1 throughout.
REQ-035 Backpressure test: SKID=1, out_ready=0, offer 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB delivered, in_ready=1 one cycle after the first transfer.
REQ-036 Flush test: occupancy=2 (0xA,0xB), flush=1 with in_valid=1, in_data=0xC -> next cycle out_valid=0, occupancy=0, out_data=RST_VAL; 0xC is never output.
REQ-037 Single-entry test: SKID=0, out_ready=0, out_valid=1 -> in_ready=0 in the same cycle; set out_ready=1 with in_valid=1, in_data=0x5 -> in_ready=1 combinationally, and 0x5 is output next cycle.
REQ-038 Async reset test: assert rst_n=0 between edges with occupancy=2 -> out_valid=0 and in_ready=0 immediately; after release, the first beat offered is output after 1 cycle.
REQ-039 Randomized test: random in_valid/out_ready/flush against a scoreboard, for SKID=0 and SKID=1 and DATA_W=1 and DATA_W=64 -> in-order delivery, no loss except flushed beats, and out_data stable under stall.
